finder_scan_sequencer: RTL and testbench



---
 rtl/finder_scan_sequencer.sv | 167 ++++++++++++++++
 tb/tb_finder_scan_sequencer.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/finder_scan_sequencer.sv
// finder_scan_sequencer: runs the horizontal finder scanner and then the
// vertical one over a captured 1-bit frame. The two scanners share the frame
// BRAM read port through a combinational mux. Each scanner's encoding vector
// is latched, and a done/maps_valid handshake tells the downstream locator
// that both maps are ready.
// Optional build macro: SEQ_SKIP_EMPTY_EN. When it is defined and the row
// scan finds no finder pattern, the sequencer goes straight to DONE and does
// not run the vertical scan.
module finder_scan_sequencer #(
  parameter int unsigned WIDTH          = 480,
  parameter int unsigned HEIGHT         = 480,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              start_in,
  output logic              h_rst_out,
  output logic              h_start_out,
  input  logic [19:0]       h_addr_in,
  output logic              h_pixel_out,
  input  logic              h_valid_in,
  input  logic [HEIGHT-1:0] h_enc_in,
  output logic              v_rst_out,
  output logic              v_start_out,
  input  logic [19:0]       v_addr_in,
  output logic              v_pixel_out,
  input  logic              v_valid_in,
  input  logic [WIDTH-1:0]  v_enc_in,
  output logic [19:0]       bram_addr_out,
  input  logic              bram_data_in,
  output logic [HEIGHT-1:0] row_map_out,
  output logic [WIDTH-1:0]  col_map_out,
  output logic              maps_valid_out,
  output logic              done_out,
  output logic              timeout_err_out,
  output logic              busy_out
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CLR, S_H_GO, S_H_RUN, S_V_GO, S_V_RUN, S_DONE, S_ABORT
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [HEIGHT-1:0] row_q, row_d;
  logic [WIDTH-1:0]  col_q, col_d;
  logic              mv_q, mv_d;
  logic              te_q, te_d;

  // State, timeout counter and captured maps
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      row_q   <= '0;
      col_q   <= '0;
      mv_q    <= 1'b0;
      te_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      row_q   <= row_d;
      col_q   <= col_d;
      mv_q    <= mv_d;
      te_q    <= te_d;
    end
  end

  // Next-state logic. maps_valid and timeout_err are updated on entry to
  // DONE/ABORT so that they are already stable while done_out pulses.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    row_d   = row_q;
    col_d   = col_q;
    mv_d    = mv_q;
    te_d    = te_q;
    unique case (state_q)
      S_IDLE: begin
        if (start_in) begin
          mv_d    = 1'b0;
          te_d    = 1'b0;
          state_d = S_CLR;
        end
      end
      S_CLR: state_d = S_H_GO;
      S_H_GO: begin
        cnt_d   = '0;
        state_d = S_H_RUN;
      end
      S_H_RUN: begin
        if (h_valid_in) begin
          row_d   = h_enc_in;
          state_d = S_V_GO;
`ifdef SEQ_SKIP_EMPTY_EN
          if (h_enc_in == '0) begin
            col_d   = '0;
            mv_d    = 1'b1;
            state_d = S_DONE;
          end
`endif
        end else if (cnt_q == CNT_LAST) begin
          te_d    = 1'b1;
          state_d = S_ABORT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_V_GO: begin
        cnt_d   = '0;
        state_d = S_V_RUN;
      end
      S_V_RUN: begin
        if (v_valid_in) begin
          col_d   = v_enc_in;
          mv_d    = 1'b1;
          state_d = S_DONE;
        end else if (cnt_q == CNT_LAST) begin
          te_d    = 1'b1;
          state_d = S_ABORT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ABORT: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Scanner control, read-port mux and status outputs decoded from state
  always_comb begin
    h_rst_out     = 1'b1;
    v_rst_out     = 1'b1;
    h_start_out   = 1'b0;
    v_start_out   = 1'b0;
    h_pixel_out   = 1'b1;
    v_pixel_out   = 1'b1;
    bram_addr_out = '0;
    unique case (state_q)
      S_H_GO, S_H_RUN: begin
        h_rst_out     = 1'b0;
        h_start_out   = (state_q == S_H_GO);
        bram_addr_out = h_addr_in;
        h_pixel_out   = bram_data_in;
      end
      S_V_GO, S_V_RUN: begin
        v_rst_out     = 1'b0;
        v_start_out   = (state_q == S_V_GO);
        bram_addr_out = v_addr_in;
        v_pixel_out   = bram_data_in;
      end
      default: ;
    endcase
  end

  assign done_out        = (state_q == S_DONE) || (state_q == S_ABORT);
  assign busy_out        = (state_q != S_IDLE);
  assign row_map_out     = row_q;
  assign col_map_out     = col_q;
  assign maps_valid_out  = mv_q;
  assign timeout_err_out = te_q;

endmodule

// File: tb/tb_finder_scan_sequencer.sv
// Directed bench for finder_scan_sequencer: the main instance uses the default
// timeout, and a second instance uses TIMEOUT_CYCLES=50 to exercise aborts.
module tb_finder_scan_sequencer;

  logic clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  logic         rst_in, start_in, t_start;
  logic [19:0]  h_addr, v_addr;
  logic         bram_data;
  logic         h_valid, v_valid, t_hv, t_vv;
  logic [479:0] h_enc, v_enc;

  logic         h_rst, h_start, h_pix, v_rst, v_start, v_pix;
  logic [19:0]  bram_addr;
  logic [479:0] row_map, col_map;
  logic         mv, done, te, busy;

  logic         t_hrst, t_hs, t_hpix, t_vrst, t_vs, t_vpix;
  logic [19:0]  t_addr;
  logic [479:0] t_row, t_col;
  logic         t_mv, t_done, t_te, t_busy;

  finder_scan_sequencer dut (
    .clk_in(clk_in), .rst_in(rst_in), .start_in(start_in),
    .h_rst_out(h_rst), .h_start_out(h_start), .h_addr_in(h_addr), .h_pixel_out(h_pix),
    .h_valid_in(h_valid), .h_enc_in(h_enc),
    .v_rst_out(v_rst), .v_start_out(v_start), .v_addr_in(v_addr), .v_pixel_out(v_pix),
    .v_valid_in(v_valid), .v_enc_in(v_enc),
    .bram_addr_out(bram_addr), .bram_data_in(bram_data),
    .row_map_out(row_map), .col_map_out(col_map), .maps_valid_out(mv),
    .done_out(done), .timeout_err_out(te), .busy_out(busy)
  );

  finder_scan_sequencer #(.TIMEOUT_CYCLES(50)) dut_to (
    .clk_in(clk_in), .rst_in(rst_in), .start_in(t_start),
    .h_rst_out(t_hrst), .h_start_out(t_hs), .h_addr_in(h_addr), .h_pixel_out(t_hpix),
    .h_valid_in(t_hv), .h_enc_in(h_enc),
    .v_rst_out(t_vrst), .v_start_out(t_vs), .v_addr_in(v_addr), .v_pixel_out(t_vpix),
    .v_valid_in(t_vv), .v_enc_in(v_enc),
    .bram_addr_out(t_addr), .bram_data_in(bram_data),
    .row_map_out(t_row), .col_map_out(t_col), .maps_valid_out(t_mv),
    .done_out(t_done), .timeout_err_out(t_te), .busy_out(t_busy)
  );

  typedef struct {
    logic [479:0] row;
    logic [479:0] col;
  } exp_t;
  exp_t sb[$];

  int errors = 0;
  int checks = 0;

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chkw(input string tag, input logic [479:0] obs, input logic [479:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [479:0] rand480();
    logic [479:0] r;
    for (int unsigned i = 0; i < 15; i++) r[i*32 +: 32] = $urandom;
    r[0] = 1'b1;
    return r;
  endfunction

  // One full sequence on the main instance; expectation pushed before stimulus.
  task automatic do_run(input int hd, input logic [479:0] he, input int vd,
                        input logic [479:0] ve, input bit poke);
    exp_t e;
    bit   skip;
    skip  = 1'b0;
    e.row = he;
    e.col = ve;
`ifdef SEQ_SKIP_EMPTY_EN
    if (he == '0) begin
      e.col = '0;
      skip  = 1'b1;
    end
`endif
    sb.push_back(e);
    start_in = 1'b1; tick(); start_in = 1'b0;
    chk1("busy_after_start", busy, 1'b1);
    for (int i = 0; i < 8 && h_start !== 1'b1; i++) tick();
    chk1("h_start_pulse", h_start, 1'b1);
    chk1("h_rst_in_hgo", h_rst, 1'b0);
    chk1("v_rst_in_hgo", v_rst, 1'b1);
    tick();
    chk1("h_start_one_cycle", h_start, 1'b0);
    bram_data = 1'b0; #1;
    chkw("addr_h_run", 480'(bram_addr), 480'(20'd1234));
    chk1("h_pix_follows_0", h_pix, 1'b0);
    chk1("v_pix_white_in_h", v_pix, 1'b1);
    bram_data = 1'b1; #1;
    chk1("h_pix_follows_1", h_pix, 1'b1);
    v_valid = 1'b1; tick(); v_valid = 1'b0;
    chk1("wrong_valid_ignored", v_start, 1'b0);
    chk1("still_h_run", h_rst, 1'b0);
    repeat (hd - 2) tick();
    h_enc = he; h_valid = 1'b1; tick(); h_valid = 1'b0;
    if (skip) begin
      chk1("skip_done_next", done, 1'b1);
      chk1("skip_no_v_start", v_start, 1'b0);
    end else begin
      for (int i = 0; i < 8 && v_start !== 1'b1; i++) tick();
      chk1("v_start_pulse", v_start, 1'b1);
      chk1("h_rst_back", h_rst, 1'b1);
      chk1("v_rst_in_vgo", v_rst, 1'b0);
      tick();
      bram_data = 1'b0; #1;
      chkw("addr_v_run", 480'(bram_addr), 480'(20'd999));
      chk1("v_pix_follows_0", v_pix, 1'b0);
      chk1("h_pix_white_in_v", h_pix, 1'b1);
      bram_data = 1'b1; #1;
      chk1("v_pix_follows_1", v_pix, 1'b1);
      if (poke) begin
        start_in = 1'b1; tick(); start_in = 1'b0;
        chk1("busy_start_ignored", v_rst, 1'b0);
      end
      repeat (vd - 2) tick();
      v_enc = ve; v_valid = 1'b1; tick(); v_valid = 1'b0;
    end
    for (int i = 0; i < 8 && done !== 1'b1; i++) tick();
    chk1("done_seen", done, 1'b1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chkw("row_map", row_map, e.row);
      chkw("col_map", col_map, e.col);
    end
    tick();
    chk1("done_one_cycle", done, 1'b0);
    chk1("maps_valid", mv, 1'b1);
    chk1("timeout_err_clear", te, 1'b0);
    chk1("idle_not_busy", busy, 1'b0);
    repeat (3) tick();
    chk1("no_second_done", done, 1'b0);
    chk1("stays_idle", busy, 1'b0);
    chkw("maps_held", row_map, e.row);
  endtask

  int n;

  initial begin
    rst_in = 1'b1; start_in = 1'b0; t_start = 1'b0;
    h_addr = 20'd1234; v_addr = 20'd999; bram_data = 1'b1;
    h_valid = 1'b0; v_valid = 1'b0; t_hv = 1'b0; t_vv = 1'b0;
    h_enc = '0; v_enc = '0;
    repeat (2) tick();
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_h_rst", h_rst, 1'b1);
    chk1("rst_v_rst", v_rst, 1'b1);
    chk1("rst_h_start", h_start, 1'b0);
    chk1("rst_v_start", v_start, 1'b0);
    chk1("rst_done", done, 1'b0);
    chk1("rst_mv", mv, 1'b0);
    chk1("rst_te", te, 1'b0);
    chkw("rst_row", row_map, '0);
    chkw("rst_col", col_map, '0);
    chkw("rst_addr", 480'(bram_addr), '0);
    chk1("rst_t_busy", t_busy, 1'b0);
    rst_in = 1'b0; tick();

    do_run(100, 480'(1) << 5, 120, 480'(1) << 7, 1'b0);
    do_run(30, rand480(), 40, rand480(), 1'b1);
    do_run(20, '0, 25, 480'(1) << 9, 1'b0);

    // Timeout: H_GO cycle, then 50 H_RUN cycles, then ABORT on the 51st tick.
    t_start = 1'b1; tick(); t_start = 1'b0;
    for (int i = 0; i < 8 && t_hs !== 1'b1; i++) tick();
    chk1("to_h_start", t_hs, 1'b1);
    n = 0;
    while (t_done !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    chkw("to_abort_latency", 480'(n), 480'(51));
    chk1("to_done", t_done, 1'b1);
    chk1("to_err", t_te, 1'b1);
    chk1("to_mv", t_mv, 1'b0);
    chk1("to_h_rst", t_hrst, 1'b1);
    chk1("to_v_rst", t_vrst, 1'b1);
    tick();
    chk1("to_done_one_cycle", t_done, 1'b0);
    chk1("to_err_level", t_te, 1'b1);
    chk1("to_idle", t_busy, 1'b0);
    t_start = 1'b1; tick(); t_start = 1'b0;
    chk1("restart_clears_err", t_te, 1'b0);
    chk1("restart_busy", t_busy, 1'b1);
    for (int i = 0; i < 8 && t_hs !== 1'b1; i++) tick();
    repeat (10) tick();
    h_enc = 480'(1) << 100; t_hv = 1'b1; tick(); t_hv = 1'b0;
    for (int i = 0; i < 8 && t_vs !== 1'b1; i++) tick();
    chk1("restart_v_start", t_vs, 1'b1);
    repeat (10) tick();
    v_enc = 480'(1) << 200; t_vv = 1'b1; tick(); t_vv = 1'b0;
    chk1("restart_done", t_done, 1'b1);
    chkw("restart_row", t_row, 480'(1) << 100);
    chkw("restart_col", t_col, 480'(1) << 200);
    tick();
    chk1("restart_mv", t_mv, 1'b1);
    chk1("restart_err_low", t_te, 1'b0);

    // Mid-run reset on the main instance while in H_RUN.
    start_in = 1'b1; tick(); start_in = 1'b0;
    for (int i = 0; i < 8 && h_start !== 1'b1; i++) tick();
    tick();
    chk1("pre_rst_h_run", h_rst, 1'b0);
    rst_in = 1'b1; tick(); rst_in = 1'b0;
    chk1("midrst_busy", busy, 1'b0);
    chk1("midrst_h_rst", h_rst, 1'b1);
    chk1("midrst_v_rst", v_rst, 1'b1);
    chkw("midrst_row", row_map, '0);
    chkw("midrst_col", col_map, '0);
    chk1("midrst_mv", mv, 1'b0);
    tick();

    do_run(10, rand480(), 10, rand480(), 1'b0);
    chkw("scoreboard_empty", 480'(sb.size()), '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
